imem_readback_tx: RTL and testbench
===================================

# imem_readback_tx

Transmit-side counterpart of the UART program loader. It reads a span of CPU instruction memory through a synchronous read port and serializes it over a dedicated 8N1 UART line, so a host can verify a freshly loaded program. It sits beside the loader in the CPU subsystem, in the `sys_clk` domain, and is triggered by a single-cycle start pulse from the CSR block.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, frequency of `clk` in Hz.
- `BAUD`, 115_200, serial bit rate. `DIV = CLK_HZ/BAUD` (integer floor) must be ≥ 2; elaboration error otherwise.
- `NUM_WORDS_IMEM`, 8192, IMEM depth in 32-bit words; power of two.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  30  first word address, `[31:2]`; sampled with `start`.
- `word_cnt`  in  16  number of words to send; sampled with `start`.
- `imem_re`  out  1  IMEM read strobe.
- `imem_raddr`  out  30  IMEM word address, `[31:2]`.
- `imem_rdat`  in  32  IMEM read data, valid the cycle after `imem_re`.
- `uart_tx`  out  1  serial output; idles high.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `imem_re`=0, `imem_raddr`=0. All internal counters and the checksum are 0.
- Stream format: header byte 0xA5, then each word as 4 bytes little-endian (bits [7:0] first), then an optional checksum byte (see Configuration).
- Byte framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly DIV cycles, so one byte takes 10·DIV cycles.
- Main FSM states:
  - IDLE → HDR on `start`. Latch `base_addr` and `word_cnt`; clear the checksum.
  - HDR → WORD if `word_cnt`≠0. Otherwise → CSUM (macro defined) or → FIN.
  - WORD sends bytes 0..3 of the current word. After byte 3: decrement the remaining count; if count ≠ 0, → WORD; else → CSUM or → FIN.
  - CSUM sends the checksum byte, then → FIN.
  - FIN pulses `done` for one cycle, then → IDLE.
- Byte sub-FSM states: START → DATA (8 bits) → STOP. A next byte, when available, starts its START bit in the cycle after STOP ends; there are no idle gaps.
- Prefetch: the read of word k is issued as a single `imem_re` cycle in the first cycle of the byte that precedes word k's byte 0 (the header, or byte 3 of word k−1). `imem_rdat` is captured into a 32-bit shift register on the following cycle.
- `imem_raddr` increments modulo NUM_WORDS_IMEM. Wrap from NUM_WORDS_IMEM−1 to 0 is legal. Bits of `base_addr` above log2(NUM_WORDS_IMEM) are ignored.
- `start` while `busy` is ignored and has no side effects.
- Reset mid-transfer: `uart_tx` returns high immediately (asynchronously), the transfer is aborted, and `done` is not pulsed.

## Timing
- `start` sampled at edge T: `busy`=1 from T+1. The header start bit drives `uart_tx` low from T+1.
- Total `busy` duration: (1 + 4·N + C)·10·DIV cycles, where N = `word_cnt` and C = 1 if the checksum is enabled, else 0.
- `done`=1 for exactly the one cycle after the last stop bit completes. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`.
- `imem_rdat` is assumed to have 1-cycle latency. `imem_raddr` is held stable while `imem_re`=1.

## Configuration
- `IMEM_READBACK_CSUM_EN` defined: after the last word, send the 8-bit XOR of all data bytes (header excluded). With `word_cnt`=0 the checksum byte is 0x00.
- `IMEM_READBACK_CSUM_EN` undefined: no checksum byte, no checksum register, and the CSUM state is absent.

## Test plan
All scenarios use CLK_HZ=1_000_000 and BAUD=250_000, giving DIV=4.
- Single word, checksum on: IMEM[0x10]=0x11223344, `start` with base 0x10, count 1 → bytes A5 44 33 22 11 44. `busy` lasts 240 cycles; exactly one `imem_re` at address 0x10; `done` pulses once.
- Wrap: NUM_WORDS_IMEM=8, base 7, count 2, IMEM[7]=0xDEADBEEF, IMEM[0]=0x01020304 → reads at 7 then 0. Bytes A5 EF BE AD DE 04 03 02 01, then checksum 0x26 (when the macro is defined).
- Zero count: count 0 → A5 00 (40+40 cycles) with the macro defined, or A5 only without it. No `imem_re` is issued.
- Ignored restart: pulse `start` again at cycle 50 of a transfer → the byte stream is unchanged, there is no second transfer, and `done` pulses once.
- Reset mid-byte: assert `rst` during a data bit of byte 2 → `uart_tx`=1 and `busy`=0 immediately. A subsequent `start` produces a clean stream from the header.
- Bit timing: check that every bit cell is exactly 4 cycles wide, with no gap between a stop bit and the next start bit, across a 3-word transfer.

Source files
------------

// File: rtl/imem_readback_tx.sv
// imem_readback_tx: streams a span of instruction memory out of an 8N1 UART as 0xA5 + words (LE).
// Define IMEM_READBACK_CSUM_EN to append an XOR checksum of all data bytes.
module imem_readback_tx #(
   parameter int CLK_HZ         = 100_000_000,
   parameter int BAUD           = 115_200,
   parameter int NUM_WORDS_IMEM = 8192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [29:0] base_addr,
   input  logic [15:0] word_cnt,
   output logic        imem_re,
   output logic [29:0] imem_raddr,
   input  logic [31:0] imem_rdat,
   output logic        uart_tx,
   output logic        busy,
   output logic        done
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int BW  = (DIV >= 2) ? $clog2(DIV) : 1;
   localparam int AW  = $clog2(NUM_WORDS_IMEM);
   localparam logic [7:0] HDR_BYTE = 8'hA5;

   if (DIV < 2) begin : g_bad_div
      $error("imem_readback_tx: CLK_HZ/BAUD must be at least 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_WORD,
`ifdef IMEM_READBACK_CSUM_EN
      S_CSUM,
`endif
      S_FIN
   } state_e;

   typedef enum logic [1:0] {B_START, B_DATA, B_STOP} bit_state_e;

   state_e          state_q, state_d;
   bit_state_e      bst_q, bst_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [1:0]      sel_q, sel_d;
   logic [7:0]      txb_q, txb_d;
   logic [31:0]     word_q, word_d;
   logic [15:0]     rem_q, rem_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            re_q, re_d;
   logic            cap_q, cap_d;
   logic            tx_q, tx_d;
`ifdef IMEM_READBACK_CSUM_EN
   logic [7:0]      csum_q, csum_d;
`endif

   logic            cell_end;
   logic            next_data;
   logic            last_data;
   logic            nxt_valid;
   logic [7:0]      nxt_byte;
   state_e          nxt_state;

   logic            unused_base_hi;
   assign unused_base_hi = ^base_addr[29:AW];

   always_comb begin
      state_d   = state_q;
      bst_d     = bst_q;
      baud_d    = baud_q;
      bit_d     = bit_q;
      sel_d     = sel_q;
      txb_d     = txb_q;
      word_d    = word_q;
      rem_d     = rem_q;
      addr_d    = addr_q;
      re_d      = 1'b0;
      cap_d     = re_q;
      tx_d      = tx_q;
`ifdef IMEM_READBACK_CSUM_EN
      csum_d    = csum_q;
`endif
      cell_end  = (baud_q == BW'(DIV - 1));
      next_data = 1'b0;
      last_data = 1'b0;
      nxt_valid = 1'b0;
      nxt_byte  = word_q[7:0];
      nxt_state = state_q;

      // Address advances only after the strobe cycle, so raddr is stable while re is high.
      if (re_q) addr_d = addr_q + AW'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               bst_d   = B_START;
               baud_d  = '0;
               tx_d    = 1'b0;
               txb_d   = HDR_BYTE;
               rem_d   = word_cnt;
               addr_d  = base_addr[AW-1:0];
               re_d    = (word_cnt != 16'd0);
`ifdef IMEM_READBACK_CSUM_EN
               csum_d  = 8'h00;
`endif
            end
         end
         S_FIN: state_d = S_IDLE;
         default: begin
            baud_d = cell_end ? '0 : baud_q + BW'(1);
            if (cell_end) begin
               case (bst_q)
                  B_START: begin
                     bst_d = B_DATA;
                     bit_d = 3'd0;
                     tx_d  = txb_q[0];
                     txb_d = txb_q >> 1;
                  end
                  B_DATA: begin
                     if (bit_q == 3'd7) begin
                        bst_d = B_STOP;
                        tx_d  = 1'b1;
                     end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = txb_q[0];
                        txb_d = txb_q >> 1;
                     end
                  end
                  default: begin
                     case (state_q)
                        S_HDR: begin
                           sel_d     = 2'd0;
                           next_data = (rem_q != 16'd0);
                           last_data = (rem_q == 16'd0);
                        end
                        S_WORD: begin
                           if (sel_q != 2'd3) begin
                              sel_d     = sel_q + 2'd1;
                              next_data = 1'b1;
                              // Byte 3 of a word is the slot that prefetches the following word.
                              re_d      = (sel_q == 2'd2) && (rem_q != 16'd1);
                           end else begin
                              rem_d     = rem_q - 16'd1;
                              sel_d     = 2'd0;
                              next_data = (rem_q != 16'd1);
                              last_data = (rem_q == 16'd1);
                           end
                        end
                        default: nxt_state = S_FIN;
                     endcase
                  end
               endcase
            end
         end
      endcase

      if (next_data) begin
         nxt_valid = 1'b1;
         nxt_byte  = word_q[7:0];
         nxt_state = S_WORD;
         word_d    = {8'h00, word_q[31:8]};
`ifdef IMEM_READBACK_CSUM_EN
         csum_d    = csum_q ^ word_q[7:0];
`endif
      end
      if (last_data) begin
`ifdef IMEM_READBACK_CSUM_EN
         nxt_valid = 1'b1;
         nxt_byte  = csum_q;
         nxt_state = S_CSUM;
`else
         nxt_state = S_FIN;
`endif
      end
      if (cell_end && bst_q == B_STOP && state_q != S_IDLE && state_q != S_FIN) begin
         state_d = nxt_state;
         if (nxt_valid) begin
            bst_d = B_START;
            tx_d  = 1'b0;
            txb_d = nxt_byte;
         end
      end

      if (cap_q) word_d = imem_rdat;
   end

   // NOTE: uart_tx resets to 1 through the async reset, so an aborted byte releases the line at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         bst_q   <= B_START;
         baud_q  <= '0;
         bit_q   <= 3'd0;
         sel_q   <= 2'd0;
         txb_q   <= 8'h00;
         word_q  <= 32'h0;
         rem_q   <= 16'd0;
         addr_q  <= '0;
         re_q    <= 1'b0;
         cap_q   <= 1'b0;
         tx_q    <= 1'b1;
`ifdef IMEM_READBACK_CSUM_EN
         csum_q  <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         bst_q   <= bst_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sel_q   <= sel_d;
         txb_q   <= txb_d;
         word_q  <= word_d;
         rem_q   <= rem_d;
         addr_q  <= addr_d;
         re_q    <= re_d;
         cap_q   <= cap_d;
         tx_q    <= tx_d;
`ifdef IMEM_READBACK_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign uart_tx    = tx_q;
   assign imem_re    = re_q;
   assign imem_raddr = 30'(addr_q);
   assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done       = (state_q == S_FIN);
endmodule

// File: tb/tb_imem_readback_tx.sv
// Bench for imem_readback_tx: UART byte decoder and read-address monitor fed from scoreboard queues.
// Follows IMEM_READBACK_CSUM_EN so the same bench covers both builds.
module tb_imem_readback_tx;
   localparam int DIV = 4;
`ifdef IMEM_READBACK_CSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [29:0] base_addr = '0;
   logic [15:0] word_cnt = '0;
   logic        imem_re;
   logic [29:0] imem_raddr;
   logic [31:0] imem_rdat;
   logic        uart_tx;
   logic        busy;
   logic        done;

   logic [31:0] mem [8];
   logic [7:0]  exp_bytes [$];
   logic [29:0] exp_addr [$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          done_cnt = 0;
   int          re_cnt = 0;

   imem_readback_tx #(
      .CLK_HZ(1_000_000), .BAUD(250_000), .NUM_WORDS_IMEM(8)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
      .imem_re(imem_re), .imem_raddr(imem_raddr), .imem_rdat(imem_rdat),
      .uart_tx(uart_tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Read data is valid only in the cycle after the strobe; other cycles carry junk.
   always @(posedge clk) imem_rdat <= imem_re ? mem[imem_raddr[2:0]] : $urandom();

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (!rst && done) done_cnt++;
      if (!rst && imem_re) begin
         re_cnt++;
         if (exp_addr.size() != 0) check("raddr", 32'(imem_raddr), 32'(exp_addr.pop_front()));
         else check("read_expected", exp_addr.size(), 1);
      end
   end

   task automatic rx_byte();
      logic [9:0] cells;
      logic       stable;
      stable = 1'b1;
      cells  = '0;
      for (int b = 0; b < 10; b++) begin
         for (int c = 0; c < DIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst) return;
            if (c == 0) cells[b] = uart_tx;
            else if (uart_tx !== cells[b]) stable = 1'b0;
         end
      end
      check("bit_width", stable, 1);
      check("framing", {cells[9], cells[0]}, 2'b10);
      if (exp_bytes.size() != 0) check("byte", cells[8:1], exp_bytes.pop_front());
      else check("byte_expected", exp_bytes.size(), 1);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && uart_tx === 1'b0) rx_byte();
      end
   end

   task automatic run_xfer(input logic [29:0] base, input int cnt, input int restart_at);
      logic [2:0]  a;
      logic [7:0]  cs;
      logic [31:0] w;
      int          cycles, d0, r0;
      logic        seen;
      cs = 8'h00;
      exp_bytes.push_back(8'hA5);
      for (int k = 0; k < cnt; k++) begin
         a = 3'(base + 30'(k));
         exp_addr.push_back(30'(a));
         w = mem[a];
         for (int b = 0; b < 4; b++) begin
            exp_bytes.push_back(w[8*b +: 8]);
            cs ^= w[8*b +: 8];
         end
      end
      if (CS == 1) exp_bytes.push_back(cs);
      d0 = done_cnt;
      r0 = re_cnt;
      @(negedge clk);
      base_addr = base;
      word_cnt  = 16'(cnt);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_rise", busy, 1);
      check("hdr_start_bit", uart_tx, 0);
      cycles = 0;
      while (busy && cycles < 20000) begin
         cycles++;
         if (cycles == restart_at) begin
            start     = 1'b1;
            base_addr = 30'h5;
            word_cnt  = 16'd3;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done_at_busy_fall", done, 1);
      check("busy_len", cycles, (1 + 4 * cnt + CS) * 10 * DIV);
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (busy) seen = 1'b1;
      end
      check("no_second_xfer", seen, 0);
      check("done_count", done_cnt - d0, 1);
      check("read_count", re_cnt - r0, cnt);
      check("bytes_left", exp_bytes.size(), 0);
      check("reads_left", exp_addr.size(), 0);
   endtask

   task automatic reset_mid_byte();
      int cycles, d0;
      d0 = done_cnt;
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(mem[0][7:0]);
      exp_addr.push_back(30'h0);
      @(negedge clk);
      base_addr = 30'h0;
      word_cnt  = 16'd2;
      start     = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      cycles = 1;
      // Busy cycle 98 falls in data bit 3 of byte 2 (bits of mem[0][15:8]).
      while (cycles < 98) begin
         @(negedge clk);
         cycles++;
      end
      check("busy_pre_reset", busy, 1);
      check("tx_pre_reset", uart_tx, mem[0][11]);
      #1 rst = 1'b1;
      #1;
      check("tx_on_reset", uart_tx, 1);
      check("busy_on_reset", busy, 0);
      check("done_on_reset", done, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (50) @(negedge clk);
      check("no_done_after_abort", done_cnt - d0, 0);
      check("abort_bytes_left", exp_bytes.size(), 0);
      check("abort_reads_left", exp_addr.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = $urandom();
      mem[0] = 32'h1122_3344;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_imem_re", imem_re, 0);
      check("rst_imem_raddr", imem_raddr, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_uart_tx", uart_tx, 1);

      // Single word; 0x10 lands on word 0 of an 8-word IMEM.
      run_xfer(30'h10, 1, 0);

      mem[7] = 32'hDEAD_BEEF;
      mem[0] = 32'h0102_0304;
      run_xfer(30'h7, 2, 0);

      run_xfer(30'h3, 0, 0);

      run_xfer(30'h1, 2, 50);

      reset_mid_byte();
      run_xfer(30'h0, 1, 0);

      run_xfer(30'h2, 3, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
